// File: rtl/mont_caster_arbiter.sv
// Round-robin front end for the single mont_caster engine: grants one requester, streams its
// operand blocks into the engine, then routes the engine's result stream back tagged with the owner.
module mont_caster_arbiter #(
    parameter int REGISTER_SIZE = 32,
    parameter int BITS_IN_NUM   = 4096,
    parameter int NUM_REQ       = 2
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic [NUM_REQ-1:0]               req_in,
    input  logic [NUM_REQ*REGISTER_SIZE-1:0] req_data_in,
    input  logic [NUM_REQ-1:0]               req_valid_in,
    output logic [NUM_REQ-1:0]               req_ready_out,
    output logic [$clog2(NUM_REQ)-1:0]       grant_out,
    output logic                             busy_out,
    input  logic                             eng_ready_in,
    output logic [REGISTER_SIZE-1:0]         eng_data_out,
    output logic                             eng_valid_out,
    input  logic [REGISTER_SIZE-1:0]         eng_data_in,
    input  logic                             eng_valid_in,
    input  logic                             eng_final_in,
    output logic [REGISTER_SIZE-1:0]         res_data_out,
    output logic                             res_valid_out,
    output logic [$clog2(NUM_REQ)-1:0]       res_id_out,
    output logic                             res_final_out
);

    localparam int BLOCKS = BITS_IN_NUM / REGISTER_SIZE;
    localparam int IDW    = $clog2(NUM_REQ);
    localparam int CW     = $clog2(BLOCKS) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   rr_next;
    logic [IDW-1:0]   winner;
    logic             found;
    logic [CW-1:0]    beat_cnt;
    logic             start;
    logic             accept;

    // Scan requesters starting at the round-robin pointer, wrapping past the top ID.
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_in[idx]) begin
                winner = IDW'(idx);
                found  = 1'b1;
            end
        end
        rr_next = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (eng_ready_in && found) begin
                    start      = 1'b1;
                    state_next = FEED;
                end
            end
            FEED: begin
                accept = req_valid_in[grant_out] && (beat_cnt < CW'(BLOCKS));
                if (accept && beat_cnt == CW'(BLOCKS - 1)) state_next = FLUSH;
            end
            FLUSH:   state_next = DRAIN;
            DRAIN:   if (eng_final_in) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready_out = '0;
        if (state == FEED) req_ready_out[grant_out] = 1'b1;
    end

    assign busy_out = (state != IDLE);

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_next;
    end

    // eng_valid_out follows accept, so gaps and the FLUSH cycle both present valid low to the engine.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rr_ptr        <= '0;
            grant_out     <= '0;
            beat_cnt      <= '0;
            eng_data_out  <= '0;
            eng_valid_out <= 1'b0;
            res_data_out  <= '0;
            res_valid_out <= 1'b0;
            res_id_out    <= '0;
            res_final_out <= 1'b0;
        end else begin
            eng_valid_out <= accept;
            if (accept) begin
                eng_data_out <= req_data_in[grant_out*REGISTER_SIZE +: REGISTER_SIZE];
                beat_cnt     <= beat_cnt + 1'b1;
            end
            if (start) begin
                grant_out <= winner;
                rr_ptr    <= rr_next;
                beat_cnt  <= '0;
            end
            res_valid_out <= (state == DRAIN) && eng_valid_in;
            res_final_out <= (state == DRAIN) && eng_final_in;
            if (state == DRAIN && eng_valid_in) begin
                res_data_out <= eng_data_in;
                res_id_out   <= grant_out;
            end
        end
    end

endmodule

// File: tb/tb_mont_caster_arbiter.sv
// Directed bench for mont_caster_arbiter: the bench plays both the requesters and the engine,
// and every expected block, grant and pulse is computed from the job seed and beat index.
module tb_mont_caster_arbiter;

    localparam int RS      = 32;
    localparam int BITS    = 4096;
    localparam int NUM_REQ = 2;
    localparam int BLOCKS  = BITS / RS;

    logic                    clk_in = 1'b0;
    logic                    rst_in;
    logic [NUM_REQ-1:0]      req_in;
    logic [NUM_REQ*RS-1:0]   req_data_in;
    logic [NUM_REQ-1:0]      req_valid_in;
    logic [NUM_REQ-1:0]      req_ready_out;
    logic [0:0]              grant_out;
    logic                    busy_out;
    logic                    eng_ready_in;
    logic [RS-1:0]           eng_data_out;
    logic                    eng_valid_out;
    logic [RS-1:0]           eng_data_in;
    logic                    eng_valid_in;
    logic                    eng_final_in;
    logic [RS-1:0]           res_data_out;
    logic                    res_valid_out;
    logic [0:0]              res_id_out;
    logic                    res_final_out;

    int vectors     = 0;
    int miscompares = 0;

    mont_caster_arbiter #(
        .REGISTER_SIZE(RS),
        .BITS_IN_NUM  (BITS),
        .NUM_REQ      (NUM_REQ)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .req_in        (req_in),
        .req_data_in   (req_data_in),
        .req_valid_in  (req_valid_in),
        .req_ready_out (req_ready_out),
        .grant_out     (grant_out),
        .busy_out      (busy_out),
        .eng_ready_in  (eng_ready_in),
        .eng_data_out  (eng_data_out),
        .eng_valid_out (eng_valid_out),
        .eng_data_in   (eng_data_in),
        .eng_valid_in  (eng_valid_in),
        .eng_final_in  (eng_final_in),
        .res_data_out  (res_data_out),
        .res_valid_out (res_valid_out),
        .res_id_out    (res_id_out),
        .res_final_out (res_final_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] feed_pat(input int seed, input int blk);
        return 32'((seed << 16) | blk);
    endfunction

    function automatic logic [31:0] res_pat(input int seed, input int i);
        return 32'hA500_0000 ^ 32'(seed << 12) ^ 32'(i);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_busy"},      busy_out,      0);
        check_output({tag, "_grant"},     grant_out,     0);
        check_output({tag, "_ready"},     req_ready_out, 0);
        check_output({tag, "_eng_valid"}, eng_valid_out, 0);
        check_output({tag, "_eng_data"},  eng_data_out,  0);
        check_output({tag, "_res_valid"}, res_valid_out, 0);
        check_output({tag, "_res_data"},  res_data_out,  0);
        check_output({tag, "_res_id"},    res_id_out,    0);
        check_output({tag, "_res_final"}, res_final_out, 0);
    endtask

    // One complete job as seen from the requesters and the engine; abort_at>0 stops feeding early.
    task automatic apply_stimulus(input logic [NUM_REQ-1:0] mask, input int exp_grant, input int seed,
                                  input int gap_at, input int gap_len, input bit other_valid,
                                  input bit feed_pulses, input int abort_at);
        int blk, gap_done, low_cnt, fwd, cycles, other, stop_at, beats;
        bit offer, accepted, gap_taken, gap_now;
        logic [NUM_REQ-1:0] onehot;
        req_in       = mask;
        eng_ready_in = 1'b1;
        tick();
        check_output("grant", grant_out, exp_grant);
        check_output("busy_feed", busy_out, 1);
        eng_ready_in = 1'b0;
        onehot = '0;
        onehot[exp_grant] = 1'b1;
        other   = (exp_grant == 0) ? 1 : 0;
        stop_at = (abort_at > 0) ? abort_at : BLOCKS;
        blk = 0; gap_done = 0; low_cnt = 0; fwd = 0; cycles = 0;
        while (blk < stop_at && cycles < BLOCKS + gap_len + 16) begin
            check_output("ready_feed", req_ready_out, onehot);
            offer = !(blk == gap_at && gap_done < gap_len);
            if (!offer) gap_done++;
            req_valid_in = '0;
            req_valid_in[exp_grant] = offer;
            req_data_in[exp_grant*RS +: RS] = feed_pat(seed, blk);
            if (other_valid) begin
                req_valid_in[other] = 1'b1;
                req_data_in[other*RS +: RS] = 32'hDEAD_0000 | 32'(blk);
            end
            eng_valid_in = feed_pulses && cycles[0];
            eng_data_in  = 32'h5A5A_0000 | 32'(cycles);
            accepted = offer && req_ready_out[exp_grant];
            tick();
            cycles++;
            if (accepted) blk++;
            check_output("res_valid_feed", res_valid_out, 0);
            check_output("eng_valid", eng_valid_out, accepted);
            if (accepted) begin
                check_output("eng_data", eng_data_out, feed_pat(seed, fwd));
                fwd++;
            end
            if (!eng_valid_out) low_cnt++;
        end
        req_valid_in = '0;
        eng_valid_in = 1'b0;
        check_output("feed_count", blk, stop_at);
        check_output("feed_gaps", low_cnt, gap_len);
        if (abort_at > 0) return;

        tick();
        check_output("flush_valid", eng_valid_out, 0);
        check_output("flush_ready", req_ready_out, 0);
        check_output("flush_busy", busy_out, 1);
        check_output("forwarded", fwd, BLOCKS);
        for (int n = 0; n < 3; n++) begin
            tick();
            check_output("compute_res_valid", res_valid_out, 0);
        end

        beats = 0;
        gap_taken = 1'b0;
        for (int n = 0; n < 2*BLOCKS + 1; n++) begin
            gap_now = (beats == 100) && !gap_taken;
            if (gap_now) begin
                gap_taken    = 1'b1;
                eng_valid_in = 1'b0;
                eng_final_in = 1'b0;
            end else begin
                eng_valid_in = 1'b1;
                eng_data_in  = res_pat(seed, beats);
                eng_final_in = (beats == 2*BLOCKS - 1);
            end
            tick();
            if (gap_now) begin
                check_output("drain_gap_valid", res_valid_out, 0);
                check_output("drain_gap_final", res_final_out, 0);
            end else begin
                check_output("res_valid", res_valid_out, 1);
                check_output("res_data", res_data_out, res_pat(seed, beats));
                check_output("res_id", res_id_out, exp_grant);
                check_output("res_final", res_final_out, (beats == 2*BLOCKS - 1));
                beats++;
            end
        end
        eng_valid_in = 1'b0;
        eng_final_in = 1'b0;
        tick();
        check_output("post_res_valid", res_valid_out, 0);
        check_output("post_res_final", res_final_out, 0);
        check_output("post_busy", busy_out, 0);
    endtask

    initial begin
        rst_in       = 1'b1;
        req_in       = '0;
        req_data_in  = '0;
        req_valid_in = '0;
        eng_ready_in = 1'b0;
        eng_data_in  = '0;
        eng_valid_in = 1'b0;
        eng_final_in = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst_in = 1'b0;

        $display("[TB] single job on requester 0");
        apply_stimulus(2'b01, 0, 1, -1, 0, 1'b0, 1'b0, 0);

        $display("[TB] both requesting, four jobs after reset");
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        apply_stimulus(2'b11, 0, 2, -1, 0, 1'b0, 1'b0, 0);
        apply_stimulus(2'b11, 1, 3, -1, 0, 1'b0, 1'b0, 0);
        apply_stimulus(2'b11, 0, 4, -1, 0, 1'b0, 1'b0, 0);
        apply_stimulus(2'b11, 1, 5, -1, 0, 1'b0, 1'b0, 0);

        $display("[TB] valid gap at beat 60, other requester valid throughout");
        apply_stimulus(2'b01, 0, 6, 60, 5, 1'b1, 1'b0, 0);

        $display("[TB] request held while engine not ready");
        req_in       = 2'b10;
        eng_ready_in = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            check_output("wait_busy", busy_out, 0);
            check_output("wait_grant", grant_out, 0);
            check_output("wait_ready", req_ready_out, 0);
        end
        apply_stimulus(2'b10, 1, 7, -1, 0, 1'b0, 1'b0, 0);

        $display("[TB] reset during feed at beat 70");
        apply_stimulus(2'b01, 0, 8, -1, 0, 1'b0, 1'b0, 70);
        rst_in       = 1'b1;
        req_in       = '0;
        req_valid_in = '0;
        tick();
        check_reset_outputs("midfeed_reset");
        rst_in = 1'b0;
        apply_stimulus(2'b11, 0, 9, -1, 0, 1'b0, 1'b0, 0);

        $display("[TB] engine valid pulses while feeding");
        apply_stimulus(2'b11, 1, 10, -1, 0, 1'b0, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
